// File: rtl/cpuout_uart_tx.sv
// Captures every change of the core's 32-bit CPUOut into a FIFO and sends each word LSB-byte-first on a UART line.
// Optional even-parity bit per byte when CPUOUT_UART_PARITY_EN is defined (default build: 8N1).
module cpuout_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 8
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [31:0]              CPUOut,
  output logic                     Tx,
  output logic                     Busy,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

`ifdef CPUOUT_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  logic [31:0]   prev;
  logic [31:0]   mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          empty;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [1:0]    byte_idx;
  logic [1:0]    byte_n;
  logic [31:0]   shreg;
  logic [31:0]   shreg_n;
  logic [7:0]    cur_byte_n;
  logic          tx_n;

  assign Level    = wptr - rptr;
  assign full     = (Level == LVL_FULL);
  assign empty    = (wptr == rptr);
  assign push_req = (CPUOut != prev);
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign push_ok  = push_req && (!full || pop);
  assign Busy     = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      prev     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push_req)
        prev <= CPUOut;
      if (push_ok)
        wptr <= wptr + PTR_ONE;
      if (pop)
        rptr <= rptr + PTR_ONE;
      if (push_req && full && !pop)
        Overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok)
      mem[wptr[AW-1:0]] <= CPUOut;
  end

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    shreg_n = shreg;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = mem[rptr[AW-1:0]];
          byte_n  = 2'd0;
          bit_n   = 3'd0;
          cyc_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cyc == CYC_LAST) begin
          cyc_n   = '0;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          cyc_n = cyc + CYC_ONE;
        end
      end
      DATA: begin
        if (cyc == CYC_LAST) begin
          cyc_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef CPUOUT_UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cyc_n = cyc + CYC_ONE;
        end
      end
`ifdef CPUOUT_UART_PARITY_EN
      PARITY: begin
        if (cyc == CYC_LAST) begin
          cyc_n   = '0;
          state_n = STOP;
        end else begin
          cyc_n = cyc + CYC_ONE;
        end
      end
`endif
      STOP: begin
        if (cyc == CYC_LAST) begin
          cyc_n = '0;
          if (byte_idx != 2'd3) begin
            byte_n  = byte_idx + 2'd1;
            shreg_n = {8'h00, shreg[31:8]};
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cyc_n = cyc + CYC_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Tx is registered, so it is derived from the state being entered.
  always_comb begin
    cur_byte_n = shreg_n[7:0];
    tx_n       = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_byte_n[bit_n];
`ifdef CPUOUT_UART_PARITY_EN
      PARITY:  tx_n = even_parity(cur_byte_n);
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      cyc      <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      Tx       <= 1'b1;
    end else begin
      state    <= state_n;
      cyc      <= cyc_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      Tx       <= tx_n;
    end
  end

  always_ff @(posedge CLK) begin
    shreg <= shreg_n;
  end

endmodule

// File: tb/tb_cpuout_uart_tx.sv
// Directed bench for cpuout_uart_tx: change capture, byte order, overflow, full+pop, reset mid-frame, optional parity.
module tb_cpuout_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef CPUOUT_UART_PARITY_EN
  localparam int WORD_CYC = 44 * CPB;
`else
  localparam int WORD_CYC = 40 * CPB;
`endif

  logic        CLK;
  logic        Reset;
  logic [31:0] CPUOut;
  logic        Tx;
  logic        Busy;
  logic [3:0]  Level;
  logic        Overflow;

  int n_vec;
  int n_err;

  logic [7:0] byte_q [$];
  logic       par_q  [$];
  int         len_q  [$];
  int         gap_q  [$];
  int         busy_run;
  int         idle_run;
  int         seen_busy;

  cpuout_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .CPUOut   (CPUOut),
    .Tx       (Tx),
    .Busy     (Busy),
    .Level    (Level),
    .Overflow (Overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // UART line monitor: mid-bit sampling on falling edges.
  initial begin : uart_mon
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(negedge CLK);
      if (Tx === 1'b0) begin
        repeat (CPB / 2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b[i] = Tx;
        end
`ifdef CPUOUT_UART_PARITY_EN
        repeat (CPB) @(negedge CLK);
        par_q.push_back(Tx);
`endif
        repeat (CPB) @(negedge CLK);
        byte_q.push_back(b);
      end
    end
  end

  // Busy run-length and idle-gap monitor.
  initial begin : busy_mon
    busy_run  = 0;
    idle_run  = 0;
    seen_busy = 0;
    forever begin
      @(negedge CLK);
      if (Busy === 1'b1) begin
        if (busy_run == 0 && seen_busy != 0)
          gap_q.push_back(idle_run);
        busy_run = busy_run + 1;
        idle_run = 0;
      end else begin
        if (busy_run != 0) begin
          len_q.push_back(busy_run);
          busy_run  = 0;
          seen_busy = 1;
        end
        idle_run = idle_run + 1;
      end
    end
  end

  task automatic clear_mon();
    byte_q.delete();
    par_q.delete();
    len_q.delete();
    gap_q.delete();
    seen_busy = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CPUOut = 32'h0;
    Reset  = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    repeat (60) @(negedge CLK);
    clear_mon();
  endtask

  task automatic wait_words(input int n, input int limit);
    for (int i = 0; i < limit && len_q.size() < n; i++)
      @(negedge CLK);
    n_vec++;
    if (len_q.size() < n) begin
      n_err++;
      $display("FAIL wait_words: got %0d words, required %0d", len_q.size(), n);
    end
  endtask

  task automatic test_reset();
    Reset  = 1'b1;
    CPUOut = 32'h0;
    repeat (3) @(negedge CLK);
    n_vec++; if (Tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", Tx); end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_vec++; if (Level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", Level); end
    n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", Overflow); end
    Reset = 1'b0;
    repeat (5) @(negedge CLK);
    n_vec++; if (Level !== 4'd0 || Busy !== 1'b0) begin n_err++; $display("FAIL idle_const: level %0d busy %b want 0 0", Level, Busy); end
    clear_mon();
  endtask

  task automatic test_single_word();
    CPUOut = 32'h0000000F;
    @(negedge CLK);
    n_vec++; if (Level !== 4'd1) begin n_err++; $display("FAIL single_level1: got %0d want 1", Level); end
    n_vec++; if (Tx !== 1'b1) begin n_err++; $display("FAIL single_tx_early: got %b want 1", Tx); end
    @(negedge CLK);
    n_vec++; if (Level !== 4'd0) begin n_err++; $display("FAIL single_level0: got %0d want 0", Level); end
    n_vec++; if (Tx !== 1'b0) begin n_err++; $display("FAIL single_tx_fall: got %b want 0", Tx); end
    n_vec++; if (Busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", Busy); end
    wait_words(1, 400);
    repeat (5) @(negedge CLK);
    n_vec++; if (len_q.size() < 1 || len_q[0] != WORD_CYC) begin n_err++; $display("FAIL single_busy_len: got %0d want %0d", (len_q.size() > 0) ? len_q[0] : -1, WORD_CYC); end
    n_vec++;
    if (byte_q.size() != 4 || byte_q[0] !== 8'h0F || byte_q[1] !== 8'h00 || byte_q[2] !== 8'h00 || byte_q[3] !== 8'h00) begin
      n_err++;
      $display("FAIL single_bytes: got %0d bytes first %h want 4 bytes 0f 00 00 00", byte_q.size(), (byte_q.size() > 0) ? byte_q[0] : 8'hxx);
    end
    clear_mon();
  endtask

  task automatic test_byte_order();
    logic [31:0] got;
    CPUOut = 32'h12345678;
    repeat (500) @(negedge CLK);
    got = 32'hxxxxxxxx;
    if (byte_q.size() >= 4) got = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
    n_vec++; if (byte_q.size() != 4 || got !== 32'h12345678) begin n_err++; $display("FAIL order_bytes: got %0d bytes word %h want 4 bytes 12345678", byte_q.size(), got); end
    n_vec++; if (len_q.size() != 1) begin n_err++; $display("FAIL order_one_word: got %0d words want 1", len_q.size()); end
    n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL order_ovf: got %b want 0", Overflow); end
    clear_mon();
  endtask

  task automatic test_overflow();
    logic [31:0] vals [10];
    logic [31:0] got;
    do_reset();
    for (int i = 0; i < 10; i++) vals[i] = 32'hA0000000 + 32'(i * 32'h01010101 + 1);
    for (int i = 0; i < 10; i++) begin
      CPUOut = vals[i];
      @(negedge CLK);
    end
    n_vec++; if (Level !== 4'd8) begin n_err++; $display("FAIL ovf_level: got %0d want 8", Level); end
    n_vec++; if (Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", Overflow); end
    wait_words(9, 2500);
    repeat (50) @(negedge CLK);
    n_vec++; if (byte_q.size() != 36) begin n_err++; $display("FAIL ovf_byte_count: got %0d want 36", byte_q.size()); end
    for (int w = 0; w < 9; w++) begin
      got = 32'hxxxxxxxx;
      if (byte_q.size() >= 4 * w + 4) got = {byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]};
      n_vec++; if (got !== vals[w]) begin n_err++; $display("FAIL ovf_word%0d: got %h want %h", w, got, vals[w]); end
    end
    n_vec++; if (gap_q.size() != 8) begin n_err++; $display("FAIL ovf_gap_count: got %0d want 8", gap_q.size()); end
    for (int g = 0; g < gap_q.size(); g++) begin
      n_vec++; if (gap_q[g] != 1) begin n_err++; $display("FAIL ovf_gap%0d: got %0d want 1", g, gap_q[g]); end
    end
    n_vec++; if (Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", Overflow); end
  endtask

  task automatic test_full_pop();
    int found;
    do_reset();
    n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf_cleared: got %b want 0", Overflow); end
    for (int i = 0; i < 9; i++) begin
      CPUOut = 32'h5000_0000 + 32'(i + 1);
      @(negedge CLK);
    end
    n_vec++; if (Level !== 4'd8 || Overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_fill: level %0d ovf %b want 8 0", Level, Overflow); end
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge CLK);
      if (Busy === 1'b0) found = 1;
    end
    n_vec++; if (found == 0) begin n_err++; $display("FAIL fullpop_idle_seen: got none want 1"); end
    CPUOut = 32'h5000_00AA;
    @(negedge CLK);
    n_vec++; if (Level !== 4'd8) begin n_err++; $display("FAIL fullpop_level: got %0d want 8", Level); end
    n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf: got %b want 0", Overflow); end
    n_vec++; if (Busy !== 1'b1) begin n_err++; $display("FAIL fullpop_busy: got %b want 1", Busy); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] got;
    do_reset();
    CPUOut = 32'hA1B2C3D4;
    for (int i = 0; i < 20 && Busy !== 1'b1; i++) @(negedge CLK);
    n_vec++; if (Busy !== 1'b1) begin n_err++; $display("FAIL mid_start: busy %b want 1", Busy); end
    repeat (95) @(negedge CLK);
    Reset  = 1'b1;
    CPUOut = 32'h0;
    @(negedge CLK);
    Reset = 1'b0;
    n_vec++; if (Tx !== 1'b1) begin n_err++; $display("FAIL mid_tx: got %b want 1", Tx); end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", Busy); end
    n_vec++; if (Level !== 4'd0) begin n_err++; $display("FAIL mid_level: got %0d want 0", Level); end
    n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL mid_ovf: got %b want 0", Overflow); end
    repeat (60) @(negedge CLK);
    clear_mon();
    repeat (200) @(negedge CLK);
    n_vec++; if (len_q.size() != 0 || byte_q.size() != 0 || Busy !== 1'b0) begin n_err++; $display("FAIL mid_no_resend: words %0d bytes %0d busy %b want 0 0 0", len_q.size(), byte_q.size(), Busy); end
    CPUOut = 32'h0055AA01;
    wait_words(1, 400);
    repeat (5) @(negedge CLK);
    got = 32'hxxxxxxxx;
    if (byte_q.size() >= 4) got = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
    n_vec++; if (byte_q.size() != 4 || got !== 32'h0055AA01) begin n_err++; $display("FAIL mid_new_word: got %0d bytes word %h want 4 bytes 0055aa01", byte_q.size(), got); end
    clear_mon();
  endtask

`ifdef CPUOUT_UART_PARITY_EN
  task automatic test_parity();
    do_reset();
    CPUOut = 32'h00000007;
    wait_words(1, 500);
    repeat (5) @(negedge CLK);
    n_vec++; if (par_q.size() != 4) begin n_err++; $display("FAIL par_count: got %0d want 4", par_q.size()); end
    n_vec++; if (par_q.size() < 1 || par_q[0] !== 1'b1) begin n_err++; $display("FAIL par_byte0: got %b want 1", (par_q.size() > 0) ? par_q[0] : 1'bx); end
    n_vec++; if (par_q.size() < 2 || par_q[1] !== 1'b0) begin n_err++; $display("FAIL par_byte1: got %b want 0", (par_q.size() > 1) ? par_q[1] : 1'bx); end
    n_vec++; if (len_q.size() < 1 || len_q[0] != 176) begin n_err++; $display("FAIL par_busy_len: got %0d want 176", (len_q.size() > 0) ? len_q[0] : -1); end
    n_vec++; if (byte_q.size() < 1 || byte_q[0] !== 8'h07) begin n_err++; $display("FAIL par_byte0_data: got %h want 07", (byte_q.size() > 0) ? byte_q[0] : 8'hxx); end
  endtask
`endif

  initial begin
    n_vec  = 0;
    n_err  = 0;
    Reset  = 1'b1;
    CPUOut = 32'h0;
    test_reset();
    test_single_word();
    test_byte_order();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
`ifdef CPUOUT_UART_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
